// File: rtl/rd_ptr_sync_decode.sv
// Read-domain write-pointer synchronizer, Gray decode, fill level and almost-empty status.
// Optional sticky occupancy error flag and clear input enabled by defining RD_LEVEL_ERR_EN.
module rd_ptr_sync_decode #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic [ADDR_WIDTH:0]   wptr_bin,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_almost_empty,
  output logic                  level_vld
`ifdef RD_LEVEL_ERR_EN
  ,
  input  logic                  clr_err,
  output logic                  level_err
`endif
);

  localparam int PW       = ADDR_WIDTH + 1;
  localparam int VLD_EDGE = SYNC_STAGES + 2;
  localparam int CW       = $clog2(VLD_EDGE + 1);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_MAX = CW'(VLD_EDGE);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] wptr_bin_q, wptr_bin_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rd_level_q, rd_level_d;
  logic          ae_q, ae_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
`ifdef RD_LEVEL_ERR_EN
  localparam logic [PW-1:0] FULL = PW'(1) << ADDR_WIDTH;
  logic          err_q, err_d;
`endif

  always_comb begin
    sync_d[0] = w_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    wptr_bin_d = gray2bin(sync_q[SYNC_STAGES-1]);
    rbin_d     = gray2bin(r_ptr_gray);
    // Modular difference handles pointer wrap without special casing.
    rd_level_d = wptr_bin_q - rbin_q;
    ae_d       = (rd_level_d <= AE_T);
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    vld_d      = (cnt_d == CNT_MAX);
`ifdef RD_LEVEL_ERR_EN
    // Set takes priority over a simultaneous clear.
    err_d      = (rd_level_d > FULL) | (err_q & ~clr_err);
`endif
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      wptr_bin_q <= '0;
      rbin_q     <= '0;
      rd_level_q <= '0;
      ae_q       <= 1'b1;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
`ifdef RD_LEVEL_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      wptr_bin_q <= wptr_bin_d;
      rbin_q     <= rbin_d;
      rd_level_q <= rd_level_d;
      ae_q       <= ae_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
`ifdef RD_LEVEL_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign wptr_bin        = wptr_bin_q;
  assign rd_level        = rd_level_q;
  assign rd_almost_empty = ae_q;
  assign level_vld       = vld_q;
`ifdef RD_LEVEL_ERR_EN
  assign level_err       = err_q;
`endif

endmodule

// File: tb/tb_rd_ptr_sync_decode.sv
// Directed bench for rd_ptr_sync_decode: steady-state vector table plus latency, threshold,
// reset and (with RD_LEVEL_ERR_EN) sticky-error sequences.
module tb_rd_ptr_sync_decode;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic [4:0] w_ptr_gray;
  logic [4:0] r_ptr_gray;
  logic [4:0] wptr_bin;
  logic [4:0] rd_level;
  logic       rd_almost_empty;
  logic       level_vld;
`ifdef RD_LEVEL_ERR_EN
  logic       clr_err;
  logic       level_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 r_clk = ~r_clk;

  rd_ptr_sync_decode #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
    .r_clk           (r_clk),
    .r_rst           (r_rst),
    .w_ptr_gray      (w_ptr_gray),
    .r_ptr_gray      (r_ptr_gray),
    .wptr_bin        (wptr_bin),
    .rd_level        (rd_level),
    .rd_almost_empty (rd_almost_empty),
    .level_vld       (level_vld)
`ifdef RD_LEVEL_ERR_EN
    ,
    .clr_err         (clr_err),
    .level_err       (level_err)
`endif
  );

  typedef struct {
    logic [4:0] w;
    logic [4:0] r;
    logic [4:0] wbin;
    logic [4:0] lvl;
    logic       ae;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  initial begin
    // w/r are Gray codes; expected values computed by hand from their binary equivalents.
    vecs[0] = '{w: 5'b00000, r: 5'b00000, wbin: 5'd0,  lvl: 5'd0,  ae: 1'b1};
    vecs[1] = '{w: 5'b00111, r: 5'b00000, wbin: 5'd5,  lvl: 5'd5,  ae: 1'b0};
    vecs[2] = '{w: 5'b00010, r: 5'b10001, wbin: 5'd3,  lvl: 5'd5,  ae: 1'b0};
    vecs[3] = '{w: 5'b11000, r: 5'b00000, wbin: 5'd16, lvl: 5'd16, ae: 1'b0};
    vecs[4] = '{w: 5'b00111, r: 5'b00011, wbin: 5'd5,  lvl: 5'd3,  ae: 1'b0};
    vecs[5] = '{w: 5'b00111, r: 5'b00010, wbin: 5'd5,  lvl: 5'd2,  ae: 1'b1};
    vecs[6] = '{w: 5'b01101, r: 5'b00000, wbin: 5'd9,  lvl: 5'd9,  ae: 1'b0};

    r_rst = 1'b0;
    w_ptr_gray = '0;
    r_ptr_gray = '0;
`ifdef RD_LEVEL_ERR_EN
    clr_err = 1'b0;
`endif
    tick(2);
    check("rst_wbin", wptr_bin, 0);
    check("rst_level", rd_level, 0);
    check("rst_ae", rd_almost_empty, 1);
    check("rst_vld", level_vld, 0);
`ifdef RD_LEVEL_ERR_EN
    check("rst_err", level_err, 0);
`endif

    r_rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check($sformatf("vld_edge%0d", e), level_vld, (e >= 4) ? 1 : 0);
    end
    check("idle_level", rd_level, 0);
    check("idle_ae", rd_almost_empty, 1);

    // Write pointer latency: wptr_bin after 3 edges, rd_level after 4.
    w_ptr_gray = 5'b00111;
    tick(2);
    check("lat_wbin_e2", wptr_bin, 0);
    tick(1);
    check("lat_wbin_e3", wptr_bin, 5);
    check("lat_lvl_e3", rd_level, 0);
    tick(1);
    check("lat_lvl_e4", rd_level, 5);
    check("lat_ae_e4", rd_almost_empty, 0);

    // Read pointer latency: 2 edges.
    r_ptr_gray = 5'b00011;
    tick(1);
    check("rlat_e1", rd_level, 5);
    tick(1);
    check("rlat_e2", rd_level, 3);

    for (int i = 0; i < 7; i++) begin
      w_ptr_gray = vecs[i].w;
      r_ptr_gray = vecs[i].r;
      tick(5);
      check($sformatf("vec%0d_wbin", i), wptr_bin, vecs[i].wbin);
      check($sformatf("vec%0d_level", i), rd_level, vecs[i].lvl);
      check($sformatf("vec%0d_ae", i), rd_almost_empty, vecs[i].ae);
`ifdef RD_LEVEL_ERR_EN
      check($sformatf("vec%0d_err", i), level_err, 0);
`endif
    end

    // Almost-empty threshold crossing 3 -> 2 -> 1.
    w_ptr_gray = 5'b00111;
    r_ptr_gray = 5'b00011;
    tick(5);
    check("ae3_level", rd_level, 3);
    check("ae3_flag", rd_almost_empty, 0);
    r_ptr_gray = 5'b00010;
    tick(1);
    check("ae_pre_flag", rd_almost_empty, 0);
    tick(1);
    check("ae2_level", rd_level, 2);
    check("ae2_flag", rd_almost_empty, 1);
    r_ptr_gray = 5'b00110;
    tick(2);
    check("ae1_level", rd_level, 1);
    check("ae1_flag", rd_almost_empty, 1);

`ifdef RD_LEVEL_ERR_EN
    w_ptr_gray = 5'b11000;
    r_ptr_gray = 5'b00000;
    tick(5);
    check("err_full_level", rd_level, 16);
    check("err_full_flag", level_err, 0);
    w_ptr_gray = 5'b11001;
    tick(4);
    check("err_ovf_level", rd_level, 17);
    check("err_set", level_err, 1);
    tick(2);
    check("err_hold", level_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("err_set_wins", level_err, 1);
    w_ptr_gray = 5'b11000;
    tick(5);
    check("err_back_level", rd_level, 16);
    check("err_sticky", level_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("err_cleared", level_err, 0);
`endif

    // Asynchronous reset mid-operation at level 9.
    w_ptr_gray = 5'b01101;
    r_ptr_gray = 5'b00000;
    tick(5);
    check("pre_rst_level", rd_level, 9);
    #2;
    r_rst = 1'b0;
    #1;
    check("async_wbin", wptr_bin, 0);
    check("async_level", rd_level, 0);
    check("async_ae", rd_almost_empty, 1);
    check("async_vld", level_vld, 0);
    tick(1);
    r_rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      check($sformatf("requal_edge%0d", e), level_vld, (e >= 4) ? 1 : 0);
    end
    check("requal_level", rd_level, 9);
    check("requal_ae", rd_almost_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rd_ptr_sync_decode.md
Name: rd_ptr_sync_decode

Overview:
Read-domain companion to the async FIFO read controller. It brings the write-domain Gray write pointer into the r_clk domain through a multi-stage synchronizer and decodes Gray back to binary, the inverse of the write side's binary-to-Gray encoding. It also decodes the local Gray read pointer and produces a registered fill level, an almost-empty flag and a pipeline-valid indication for read-side flow control and status.

Parameters:
ADDR_WIDTH, 4, FIFO address width; pointers are ADDR_WIDTH+1 bits, depth = 2^ADDR_WIDTH.
SYNC_STAGES, 2, number of synchronizer flops on w_ptr_gray; legal range 2..4.
AE_THRESH, 2, almost-empty threshold in entries; legal range 0..2^ADDR_WIDTH.

Ports:
r_clk  in  1  read-domain clock.
r_rst  in  1  asynchronous, active-low reset.
w_ptr_gray  in  ADDR_WIDTH+1  Gray write pointer, launched from the w_clk domain.
r_ptr_gray  in  ADDR_WIDTH+1  Gray read pointer from the read controller, already in the r_clk domain.
clr_err  in  1  clears the sticky level_err (present only with the optional feature).
wptr_bin  out  ADDR_WIDTH+1  synchronized, decoded binary write pointer.
rd_level  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH.
rd_almost_empty  out  1  high when rd_level <= AE_THRESH.
level_vld  out  1  high once the synchronizer and decode pipeline has filled after reset.
level_err  out  1  sticky flag for an impossible occupancy (present only with the optional feature).

Behaviour:
- Reset (r_rst low, asynchronous):
  - Synchronizer flops, wptr_bin, rd_level, the fill counter and level_err clear to 0.
  - rd_almost_empty = 1, level_vld = 0.
  - Reset asserted mid-operation has the same effect immediately, with no dependency on r_clk.
- Synchronizer: a SYNC_STAGES-deep flop chain on w_ptr_gray. Only the last stage, wq, feeds logic; no combinational path from w_ptr_gray reaches any output.
- Gray decode, applied to wq and to r_ptr_gray:
  - b[ADDR_WIDTH] = g[ADDR_WIDTH].
  - b[i] = b[i+1] XOR g[i], for i from ADDR_WIDTH-1 down to 0.
- Stage A: on each r_clk edge, wptr_bin <= decode(wq) and an internal rbin <= decode(r_ptr_gray). Both are registered in the same cycle.
- Stage B: rd_level <= (wptr_bin - rbin) modulo 2^(ADDR_WIDTH+1). The subtraction wraps naturally at ADDR_WIDTH+1 bits; no special handling at pointer wrap.
- rd_almost_empty: registered with rd_level, computed as (next rd_level <= AE_THRESH).
- Latency:
  - w_ptr_gray change to wptr_bin update: SYNC_STAGES+1 r_clk edges.
  - w_ptr_gray change to rd_level update: SYNC_STAGES+2 edges.
  - r_ptr_gray change to rd_level update: 2 edges.
- level_vld:
  - A small saturating counter counts r_clk edges after reset release.
  - level_vld asserts on edge SYNC_STAGES+2 and stays high until the next reset.
  - While level_vld is low, rd_level and rd_almost_empty are still computed but must not be used by consumers.
- Full boundary: rd_level = 2^ADDR_WIDTH is legal (FIFO full as seen from the read side). 0 is legal (empty).
- Multiple write increments between r_clk samples are legal, since w_clk may be faster. The level jumps by the accumulated amount with no error.

Optional Feature:
Macro RD_LEVEL_ERR_EN.
- Defined:
  - level_err sets when the next rd_level exceeds 2^ADDR_WIDTH, which indicates pointer corruption or a synchronizer fault.
  - level_err holds until clr_err is sampled high on an r_clk edge.
  - If set and clear occur in the same cycle, set wins.
- Not defined: the level_err and clr_err ports and all related logic are absent.

Test Plan:
- Reset, then release; hold w_ptr_gray = r_ptr_gray = 0 -> outputs 0, rd_almost_empty = 1, level_vld rises exactly at edge 4 (SYNC_STAGES = 2).
- r_ptr_gray = 0; w_ptr_gray steps to 00111 (bin 5) -> wptr_bin = 5 after 3 edges, rd_level = 5 and rd_almost_empty = 0 after 4 edges.
- Wrap: w_ptr_gray = 00010 (bin 3), r_ptr_gray = 10001 (bin 30) -> rd_level = 5, level_err = 0.
- Full: w_ptr_gray = 11000 (bin 16), r_ptr_gray = 0 -> rd_level = 16, no error. Then w_ptr_gray = 11001 (bin 17) -> level_err = 1 and stays set. Then clr_err pulsed while the level is still 17 -> level_err stays 1. Then w_ptr_gray back to 11000 and clr_err pulsed -> level_err = 0.
- Almost-empty edge: rd_level stepping 3 -> 2 -> 1 via r_ptr_gray with AE_THRESH = 2 -> rd_almost_empty goes 0 -> 1 in the same cycle rd_level becomes 2.
- Reset mid-operation at rd_level = 9 -> all outputs return to reset values asynchronously, and level_vld re-qualifies after 4 edges.
